// File: rtl/axil_ctrl_master_if.sv
// Command/response and AXI-Lite master bundle for axil_ctrl_master.
// The master modport is the controller's view; slave is the attached requester/responder view.
interface axil_ctrl_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;
    logic        rsp_timeout;

    logic [31:0] ctrl_awaddr;
    logic        ctrl_awvalid;
    logic        ctrl_awready;
    logic [31:0] ctrl_wdata;
    logic [3:0]  ctrl_wstrb;
    logic        ctrl_wvalid;
    logic        ctrl_wready;
    logic [1:0]  ctrl_bresp;
    logic        ctrl_bvalid;
    logic        ctrl_bready;
    logic [31:0] ctrl_araddr;
    logic        ctrl_arvalid;
    logic        ctrl_arready;
    logic [31:0] ctrl_rdata;
    logic [1:0]  ctrl_rresp;
    logic        ctrl_rvalid;
    logic        ctrl_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_write, rsp_timeout,
        input  rsp_ready,
        output ctrl_awaddr, ctrl_awvalid, input ctrl_awready,
        output ctrl_wdata, ctrl_wstrb, ctrl_wvalid, input ctrl_wready,
        input  ctrl_bresp, ctrl_bvalid, output ctrl_bready,
        output ctrl_araddr, ctrl_arvalid, input ctrl_arready,
        input  ctrl_rdata, ctrl_rresp, ctrl_rvalid, output ctrl_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_write, rsp_timeout,
        output rsp_ready,
        input  ctrl_awaddr, ctrl_awvalid, output ctrl_awready,
        input  ctrl_wdata, ctrl_wstrb, ctrl_wvalid, output ctrl_wready,
        output ctrl_bresp, ctrl_bvalid, input ctrl_bready,
        input  ctrl_araddr, ctrl_arvalid, output ctrl_arready,
        output ctrl_rdata, ctrl_rresp, ctrl_rvalid, input ctrl_rready
    );
endinterface

// File: rtl/axil_ctrl_master.sv
// Single-outstanding AXI-Lite master: one command in, one registered completion out.
// Define AXIL_MASTER_TIMEOUT_EN to abort transactions outstanding for TIMEOUT_CYCLES cycles.
module axil_ctrl_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic               aclk,
    input logic               areset,
    axil_ctrl_master_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RA   = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        arvalid_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_resp_q;
    logic        rsp_write_q;
    logic        rsp_timeout_q;

    logic cmd_ready;
    logic cmd_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic ar_fire;
    logic r_fire;
    logic wr_done;
    logic busy;
    logic to_expire;

    // cmd_ready is gated by the raw reset so it is low throughout reset and high the first cycle after
    assign cmd_ready = (state == S_IDLE) && !areset;
    assign cmd_fire  = bus.cmd_valid && cmd_ready;
    assign aw_fire   = awvalid_q && bus.ctrl_awready;
    assign w_fire    = wvalid_q && bus.ctrl_wready;
    assign b_fire    = (state == S_WB) && bus.ctrl_bvalid;
    assign ar_fire   = arvalid_q && bus.ctrl_arready;
    assign r_fire    = (state == S_RD) && bus.ctrl_rvalid;
    assign wr_done   = (state == S_WR) && (!awvalid_q || aw_fire) && (!wvalid_q || w_fire);
    assign busy      = (state == S_WR) || (state == S_WB) || (state == S_RA) || (state == S_RD);

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            to_cnt <= '0;
        end else if (cmd_fire) begin
            to_cnt <= '0;
        end else if (busy) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Expiry on the edge where the count would reach TIMEOUT_CYCLES; it overrides a coincident handshake
    assign to_expire = busy && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_expire          = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_write_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else if (to_expire) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b11;
            rsp_write_q   <= write_q;
            rsp_timeout_q <= 1'b1;
            state         <= S_RSP;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        addr_q  <= bus.cmd_addr;
                        wdata_q <= bus.cmd_wdata;
                        write_q <= bus.cmd_write;
                        if (bus.cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= S_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= S_RA;
                        end
                    end
                end
                S_WR: begin
                    if (aw_fire) awvalid_q <= 1'b0;
                    if (w_fire)  wvalid_q  <= 1'b0;
                    if (wr_done) state     <= S_WB;
                end
                S_WB: begin
                    if (b_fire) begin
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= bus.ctrl_bresp;
                        rsp_write_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        state         <= S_RSP;
                    end
                end
                S_RA: begin
                    if (ar_fire) begin
                        arvalid_q <= 1'b0;
                        state     <= S_RD;
                    end
                end
                S_RD: begin
                    if (r_fire) begin
                        rsp_rdata_q   <= bus.ctrl_rdata;
                        rsp_resp_q    <= bus.ctrl_rresp;
                        rsp_write_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        state         <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.rsp_valid    = (state == S_RSP);
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_resp     = rsp_resp_q;
    assign bus.rsp_write    = rsp_write_q;
    assign bus.rsp_timeout  = rsp_timeout_q;

    assign bus.ctrl_awaddr  = addr_q;
    assign bus.ctrl_awvalid = awvalid_q;
    assign bus.ctrl_wdata   = wdata_q;
    assign bus.ctrl_wstrb   = 4'hF;
    assign bus.ctrl_wvalid  = wvalid_q;
    assign bus.ctrl_bready  = (state == S_WB);
    assign bus.ctrl_araddr  = addr_q;
    assign bus.ctrl_arvalid = arvalid_q;
    assign bus.ctrl_rready  = (state == S_RD);

endmodule

// File: tb/tb_axil_ctrl_master.sv
// Randomized bench for axil_ctrl_master: memory-backed AXI-Lite responder plus a memory reference model.
// Build with AXIL_MASTER_TIMEOUT_EN defined to exercise the abort path instead of the indefinite wait.
module tb_axil_ctrl_master;

    localparam int unsigned TO_CYC = 16;

    logic aclk;
    logic areset;

    axil_ctrl_master_if bus ();

    axil_ctrl_master #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Responder rules shared by the slave and the reference model
    function automatic logic [31:0] fill_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[5:4];
    endfunction

    // Responder knobs driven by the main sequence
    int unsigned ready_mode = 0;
    logic        r_hold     = 1'b0;
    logic        ar_never   = 1'b0;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    initial begin
        logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
        logic        aw_have, w_have, ar_have;
        logic [31:0] aw_cap, w_cap, ar_cap, aw_addr, w_dat, ar_addr;
        int unsigned aw_wait;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        aw_have = 0; w_have = 0; ar_have = 0; aw_wait = 0;
        aw_cap = '0; w_cap = '0; ar_cap = '0; aw_addr = '0; w_dat = '0; ar_addr = '0;
        bus.ctrl_awready = 0; bus.ctrl_wready = 0; bus.ctrl_arready = 0;
        bus.ctrl_bvalid = 0; bus.ctrl_bresp = '0;
        bus.ctrl_rvalid = 0; bus.ctrl_rresp = '0; bus.ctrl_rdata = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
                aw_have = 0; w_have = 0; ar_have = 0; aw_wait = 0;
                bus.ctrl_awready = 0; bus.ctrl_wready = 0; bus.ctrl_arready = 0;
                bus.ctrl_bvalid = 0; bus.ctrl_rvalid = 0;
                continue;
            end
            // Apply handshakes that completed on the rising edge just passed
            if (aw_hs) begin aw_have = 1; aw_addr = aw_cap; aw_wait = 0; end
            if (w_hs)  begin w_have = 1; w_dat = w_cap; end
            if (ar_hs) begin ar_have = 1; ar_addr = ar_cap; end
            if (b_hs)  bus.ctrl_bvalid = 0;
            if (r_hs)  bus.ctrl_rvalid = 0;
            if (aw_have && w_have && !bus.ctrl_bvalid && (ready_mode != 0 || $urandom_range(0, 1) == 1)) begin
                slave_mem[aw_addr] = w_dat;
                bus.ctrl_bresp  = resp_of(aw_addr);
                bus.ctrl_bvalid = 1;
                aw_have = 0; w_have = 0;
            end
            if (ar_have && !bus.ctrl_rvalid && !r_hold && (ready_mode != 0 || $urandom_range(0, 1) == 1)) begin
                bus.ctrl_rdata  = slave_mem.exists(ar_addr) ? slave_mem[ar_addr] : fill_of(ar_addr);
                bus.ctrl_rresp  = resp_of(ar_addr);
                bus.ctrl_rvalid = 1;
                ar_have = 0;
            end
            if (bus.ctrl_awvalid) aw_wait++;
            if (ready_mode == 1) begin
                bus.ctrl_wready  = 1;
                bus.ctrl_awready = (aw_wait > 3);
                bus.ctrl_arready = 1;
            end else begin
                bus.ctrl_awready = ($urandom_range(0, 2) != 0);
                bus.ctrl_wready  = ($urandom_range(0, 2) != 0);
                bus.ctrl_arready = ($urandom_range(0, 2) != 0);
            end
            if (ar_never) bus.ctrl_arready = 0;
            aw_hs = bus.ctrl_awvalid && bus.ctrl_awready; aw_cap = bus.ctrl_awaddr;
            w_hs  = bus.ctrl_wvalid && bus.ctrl_wready;   w_cap  = bus.ctrl_wdata;
            ar_hs = bus.ctrl_arvalid && bus.ctrl_arready; ar_cap = bus.ctrl_araddr;
            b_hs  = bus.ctrl_bvalid && bus.ctrl_bready;
            r_hs  = bus.ctrl_rvalid && bus.ctrl_rready;
        end
    end

    // Protocol monitor: valid/payload stability and handshake counts
    int unsigned b_cnt = 0;
    int unsigned rsp_cnt = 0;
    int unsigned aw_only_cycles = 0;

    initial begin
        logic        p_aw, p_w, p_ar, p_aw_hs, p_w_hs, p_ar_hs, p_rst;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        p_aw = 0; p_w = 0; p_ar = 0; p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_rst = 1;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0;
        forever begin
            @(negedge aclk);
            #1;
            if (!areset && !p_rst && !(bus.rsp_valid && bus.rsp_timeout)) begin
                if (p_aw_hs) check_eq("awvalid_drop", bus.ctrl_awvalid, 0);
                else if (p_aw) begin
                    check_eq("awvalid_hold", bus.ctrl_awvalid, 1);
                    check_eq("awaddr_hold", bus.ctrl_awaddr, p_awaddr);
                end
                if (p_w_hs) check_eq("wvalid_drop", bus.ctrl_wvalid, 0);
                else if (p_w) begin
                    check_eq("wvalid_hold", bus.ctrl_wvalid, 1);
                    check_eq("wdata_hold", bus.ctrl_wdata, p_wdata);
                end
                if (p_ar_hs) check_eq("arvalid_drop", bus.ctrl_arvalid, 0);
                else if (p_ar) begin
                    check_eq("arvalid_hold", bus.ctrl_arvalid, 1);
                    check_eq("araddr_hold", bus.ctrl_araddr, p_araddr);
                end
            end
            if (bus.ctrl_awvalid && !bus.ctrl_wvalid) aw_only_cycles++;
            if (bus.ctrl_bvalid && bus.ctrl_bready) b_cnt++;
            if (bus.rsp_valid && bus.rsp_ready) rsp_cnt++;
            p_aw = bus.ctrl_awvalid; p_aw_hs = bus.ctrl_awvalid && bus.ctrl_awready; p_awaddr = bus.ctrl_awaddr;
            p_w  = bus.ctrl_wvalid;  p_w_hs  = bus.ctrl_wvalid && bus.ctrl_wready;   p_wdata  = bus.ctrl_wdata;
            p_ar = bus.ctrl_arvalid; p_ar_hs = bus.ctrl_arvalid && bus.ctrl_arready; p_araddr = bus.ctrl_araddr;
            p_rst = areset;
        end
    end

    // Called and returns on a falling edge; returns one cycle after the accepting edge
    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned n;
        bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin @(negedge aclk); n++; end
        check_eq("cmd_accept", bus.cmd_ready, 1);
        @(negedge aclk);
        bus.cmd_valid = 0;
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int unsigned hold);
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int unsigned n;
        if (wr) begin
            model_mem[addr] = wdata;
            exp_rdata = '0;
        end else begin
            exp_rdata = model_mem.exists(addr) ? model_mem[addr] : fill_of(addr);
        end
        exp_resp = resp_of(addr);
        issue_cmd(wr, addr, wdata);
        n = 0;
        while (!bus.rsp_valid && n < 200) begin @(negedge aclk); n++; end
        check_eq("rsp_valid", bus.rsp_valid, 1);
        for (int unsigned h = 0; h <= hold; h++) begin
            check_eq("rsp_write", bus.rsp_write, wr);
            check_eq("rsp_resp", bus.rsp_resp, exp_resp);
            check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
            check_eq("rsp_timeout", bus.rsp_timeout, 0);
            if (h != 0) begin
                check_eq("rsp_valid_held", bus.rsp_valid, 1);
                check_eq("cmd_ready_in_rsp", bus.cmd_ready, 0);
            end
            if (h != hold) @(negedge aclk);
        end
        bus.rsp_ready = 1;
        @(negedge aclk);
        bus.rsp_ready = 0;
        check_eq("rsp_valid_clear", bus.rsp_valid, 0);
        check_eq("cmd_ready_idle", bus.cmd_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned b0, r0, a0, n;
        logic [31:0] addr;
        areset = 1;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 0;

        // Reset state
        repeat (2) @(negedge aclk);
        check_eq("rst_cmd_ready", bus.cmd_ready, 0);
        check_eq("rst_valids", {bus.ctrl_awvalid, bus.ctrl_wvalid, bus.ctrl_arvalid,
                                bus.ctrl_bready, bus.ctrl_rready, bus.rsp_valid}, 0);
        check_eq("rst_rsp", {bus.rsp_rdata[29:0], bus.rsp_resp}, 0);
        check_eq("rst_rsp_flags", {bus.rsp_write, bus.rsp_timeout}, 0);
        check_eq("rst_awaddr", bus.ctrl_awaddr, 0);
        check_eq("rst_wdata", bus.ctrl_wdata, 0);
        check_eq("rst_araddr", bus.ctrl_araddr, 0);
        check_eq("wstrb", bus.ctrl_wstrb, 4'hF);
        @(posedge aclk); #3 areset = 0;
        @(negedge aclk);
        check_eq("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Basic write then read-back
        run_txn(1, 32'h0, 32'h5, 0);
        run_txn(0, 32'h0, 32'h0, 0);

        // W accepted three cycles ahead of AW
        ready_mode = 1;
        b0 = b_cnt; r0 = rsp_cnt; a0 = aw_only_cycles;
        run_txn(1, 32'h4000_0014, 32'hCAFE_0001, 0);
        check_eq("w_first_aw_only", aw_only_cycles - a0, 3);
        check_eq("w_first_b_count", b_cnt - b0, 1);
        check_eq("w_first_rsp_count", rsp_cnt - r0, 1);
        ready_mode = 0;

        // Completion held off for 10 cycles
        run_txn(0, 32'h4000_0014, 32'h0, 10);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            addr = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
            b0 = b_cnt;
            if ($urandom_range(0, 1) == 1) begin
                run_txn(1, addr, $urandom, $urandom_range(0, 3));
                check_eq("rand_b_count", b_cnt - b0, 1);
            end else begin
                run_txn(0, addr, 32'h0, $urandom_range(0, 3));
                check_eq("rand_b_count", b_cnt - b0, 0);
            end
        end

        // Reset while awaiting R
        r_hold = 1;
        r0 = rsp_cnt;
        issue_cmd(0, 32'h4000_0008, 32'h0);
        n = 0;
        while (!bus.ctrl_rready && n < 100) begin @(negedge aclk); n++; end
        check_eq("reach_rd", bus.ctrl_rready, 1);
        @(posedge aclk); #3 areset = 1;
        #1;
        check_eq("async_rst_valids", {bus.ctrl_awvalid, bus.ctrl_wvalid, bus.ctrl_arvalid,
                                      bus.ctrl_bready, bus.ctrl_rready, bus.cmd_ready}, 0);
        check_eq("async_rst_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(posedge aclk);
        #3 areset = 0;
        r_hold = 0;
        @(negedge aclk);
        check_eq("rst_rd_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_rd_no_rsp", bus.rsp_valid, 0);
        check_eq("rst_rd_rsp_count", rsp_cnt - r0, 0);
        run_txn(0, 32'h4000_0008, 32'h0, 0);
        run_txn(1, 32'h4000_0008, 32'h1234_5678, 1);

        // AR never accepted
        ar_never = 1;
        issue_cmd(0, 32'h4000_0030, 32'h0);
`ifdef AXIL_MASTER_TIMEOUT_EN
        n = 1;
        while (!bus.rsp_valid && n < 100) begin @(negedge aclk); n++; end
        check_eq("timeout_latency", n, TO_CYC + 1);
        check_eq("timeout_flag", bus.rsp_timeout, 1);
        check_eq("timeout_resp", bus.rsp_resp, 2'b11);
        check_eq("timeout_rdata", bus.rsp_rdata, 0);
        check_eq("timeout_write", bus.rsp_write, 0);
        check_eq("timeout_arvalid", bus.ctrl_arvalid, 0);
        bus.rsp_ready = 1;
        @(negedge aclk);
        bus.rsp_ready = 0;
        check_eq("timeout_cmd_ready", bus.cmd_ready, 1);
        ar_never = 0;
`else
        repeat (1000) @(negedge aclk);
        check_eq("no_timeout_arvalid", bus.ctrl_arvalid, 1);
        check_eq("no_timeout_rsp_valid", bus.rsp_valid, 0);
        @(posedge aclk); #3 areset = 1;
        repeat (2) @(posedge aclk);
        #3 areset = 0;
        ar_never = 0;
        @(negedge aclk);
`endif
        run_txn(0, 32'h0, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axil_ctrl_master.md
AXIL_CTRL_MASTER -- requirements
Module: axil_ctrl_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles a transaction may stay outstanding before abort (used only when AXIL_MASTER_TIMEOUT_EN is defined).
REQ-002 SHALL have port aclk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port areset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1: command present.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr, input, 32: target address.
REQ-008 SHALL have port cmd_wdata, input, 32: write data (ignored for reads).
REQ-009 SHALL have port rsp_valid, output, 1: completion present.
REQ-010 SHALL have port rsp_ready, input, 1: completion consumed.
REQ-011 SHALL have port rsp_rdata, output, 32: read data (0 for writes).
REQ-012 SHALL have port rsp_resp, output, 2: AXI response code.
REQ-013 SHALL have port rsp_write, output, 1: completion belongs to a write.
REQ-014 SHALL have port rsp_timeout, output, 1: transaction was aborted.
REQ-015 SHALL have the AXI-Lite master ports ctrl_awaddr[32], ctrl_awvalid, ctrl_awready, ctrl_wdata[32], ctrl_wstrb[4], ctrl_wvalid, ctrl_wready, ctrl_bresp[2], ctrl_bvalid, ctrl_bready, ctrl_araddr[32], ctrl_arvalid, ctrl_arready, ctrl_rdata[32], ctrl_rresp[2], ctrl_rvalid and ctrl_rready, with the direction opposite to a responder.

Function
REQ-016 SHALL implement the states IDLE, WR (AW/W outstanding), WB (awaiting B), RA (AR outstanding), RD (awaiting R) and RSP.
REQ-017 SHALL drive cmd_ready = 1 only in IDLE; on acceptance, latch addr/wdata/write and go to WR (write) or RA (read) on the next cycle.
REQ-018 SHALL, in WR, assert ctrl_awvalid and ctrl_wvalid together, drop each independently the cycle after its own handshake, and go to WB once both are done, including simultaneous or either-order acceptance.
REQ-019 SHALL drive ctrl_wstrb = 4'hF constantly.
REQ-020 SHALL, in WB, hold ctrl_bready = 1; on the B handshake, capture bresp, set rdata = 0 and go to RSP.
REQ-021 SHALL, in RA, assert ctrl_arvalid until the AR handshake, then go to RD.
REQ-022 SHALL, in RD, hold ctrl_rready = 1; on the R handshake, capture rdata/rresp and go to RSP.
REQ-023 SHALL, in RSP, hold rsp_valid = 1 with stable rsp_* until rsp_ready, then return to IDLE; rsp_* outputs SHALL be registered.
REQ-024 SHALL keep every AXI valid stable and unchanged once asserted until its handshake (except on timeout abort).
REQ-025 SHALL ignore ctrl_bvalid/ctrl_rvalid outside WB/RD (ready low).
REQ-026 SHALL sustain a minimum latency of 1 cycle (cmd accept) + AXI handshakes + 1 cycle to rsp_valid; no pipelining, one outstanding transaction.

Reset
REQ-027 SHALL, while areset is high, force state IDLE and all valids/readies low (cmd_ready low during reset, high the first cycle after).
REQ-028 SHALL reset rsp_rdata, rsp_resp, rsp_write, rsp_timeout, ctrl_awaddr, ctrl_wdata and ctrl_araddr to 0.
REQ-029 SHALL abandon any in-flight transaction on reset mid-operation without producing a response.

Configuration
REQ-030 SHALL, with AXIL_MASTER_TIMEOUT_EN defined, implement a counter that clears on command acceptance and increments in WR/WB/RA/RD; on reaching TIMEOUT_CYCLES it SHALL drop all AXI valids/readies and enter RSP with rsp_timeout = 1, rsp_resp = 2'b11 and rsp_rdata = 0.
REQ-031 SHALL, without AXIL_MASTER_TIMEOUT_EN, have no counter, tie rsp_timeout = 0 and wait indefinitely.

Verification
REQ-032 SHALL cover: write addr 0x0, data 0x5 to the NMU control block -> rsp_valid, rsp_write = 1, rsp_resp = 0; the subsequent read -> rsp_rdata = 0x5.
REQ-033 SHALL cover: wready asserted 3 cycles before awready -> wvalid drops after the W handshake, awvalid held, exactly one B, single response.
REQ-034 SHALL cover: rsp_ready held low for 10 cycles -> rsp_* stable and cmd_ready = 0 throughout.
REQ-035 SHALL cover: areset pulsed while in RD -> all valids/readies 0 asynchronously, no rsp_valid, next command completes normally.
REQ-036 SHALL cover: with the macro and TIMEOUT_CYCLES = 16 and a responder that never asserts arready -> rsp_timeout = 1 and rsp_resp = 2'b11 after 16 cycles; without the macro -> arvalid still high at 1000 cycles.
